reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised reset controller for the matrix-accelerator SoC top. It replaces a plain "PLL locked AND external reset" gate with synchronised, glitch-filtered lock qualification and staggered release of `NUM_DOMAINS` reset domains (e.g. HBM, interconnect, core, UART). It also adds a software-requested reset and a lock-loss counter. It sits between the PLL outputs and `matrix_accelerator_soc`, clocked by the 100 MHz system clock.

## Interface
Parameters:
- `NUM_DOMAINS`, default 4: number of reset outputs, ≥1.
- `LOCK_FILTER`, default 16: consecutive good synchronised cycles required before release, ≥1.
- `STAGGER`, default 8: cycles between consecutive domain releases, ≥1.
- `SW_RST_CYCLES`, default 32: assertion length of a software reset, ≥1.

Ports:
- `clk` in 1: system clock. The block has one clock; all logic is on `clk`.
- `rst` in 1: reset, synchronous and active-high.
- `pll_locked_i` in 1: PLL lock, asynchronous to `clk`.
- `ext_rst_n_i` in 1: board reset, active-low, asynchronous to `clk`.
- `sw_rst_req_i` in 1: single-cycle software reset request, synchronous to `clk`.
- `rst_n_o` out `NUM_DOMAINS`: per-domain active-low resets, registered.
- `all_released_o` out 1: high when every domain is released.
- `lock_loss_cnt_o` out 8: saturating count of lock-loss events.

## Operation
- `pll_locked_i` and `ext_rst_n_i` each pass through a 2-flop synchroniser. `good` = sync_locked & sync_ext_n.
- FSM states:
  - **HOLD**: all `rst_n_o`=0. If `good`, go to FILTER with filter count = 1.
  - **FILTER**: count consecutive `good` cycles. If `!good`, go to HOLD and clear the count. When the count reaches `LOCK_FILTER`, go to RELEASE and set `rst_n_o[0]`=1.
  - **RELEASE**: domain k (index 0 first) is released `k*STAGGER` cycles after domain 0. Released domains stay released. When the last domain is released, go to RUN.
  - **RUN**: `all_released_o`=1. If `sw_rst_req_i`, go to SWRST.
  - **SWRST**: all `rst_n_o`=0 for `SW_RST_CYCLES` cycles, then go to FILTER with the count cleared.
- `!good` in FILTER, RELEASE, RUN or SWRST:
  - Go to HOLD.
  - Set all `rst_n_o`=0 and `all_released_o`=0 on the next edge.
  - Loss of `good` overrides `sw_rst_req_i` in the same cycle.
- `sw_rst_req_i` is ignored outside RUN.
- `lock_loss_cnt_o` increments by 1 when RELEASE or RUN exits because sync_locked=0. Exits caused only by ext reset do not count. The counter saturates at 255 and is cleared only by `rst`.
- `rst` mid-operation:
  - Next edge: state HOLD, all counters 0, synchroniser flops 0 (treated as not good).
  - All `rst_n_o`=0, `all_released_o`=0, `lock_loss_cnt_o`=0.

## Timing
- Reset values: `rst_n_o`=0, `all_released_o`=0, `lock_loss_cnt_o`=0.
- Clock edges are numbered from edge 0, the first edge that samples raw `pll_locked_i`=1 with `ext_rst_n_i` already high and stable:
  - sync output `good` at edge 2;
  - `rst_n_o[0]` rises at edge `LOCK_FILTER+2`;
  - `rst_n_o[k]` rises at edge `LOCK_FILTER+2+k*STAGGER`.
- `all_released_o` rises in the same cycle as `rst_n_o[NUM_DOMAINS-1]`.
- Bad-input latency: raw input sampled bad at edge e gives all outputs low at edge e+3 (2 synchroniser edges + 1 registered output).
- SW reset: request sampled at edge s gives all outputs low at edge s+1 and held through edge s+`SW_RST_CYCLES`. Re-release `rst_n_o[0]` rises at edge s+`SW_RST_CYCLES`+`LOCK_FILTER`+1.
- Single-cycle glitches on raw inputs are not required to be filtered by the synchroniser. Any `!good` cycle restarts FILTER.

## Structure
- `reset_seq_pkg`: `state_e` enum (HOLD, FILTER, RELEASE, RUN, SWRST) and the `LOSS_CNT_W`=8 constant.
- Sub-module `sync_2ff`: generic 2-flop synchroniser with a reset value parameter. It is instantiated twice.
- A single down/up counter is shared between FILTER, RELEASE and SWRST, sized `$clog2` of the largest of `LOCK_FILTER`, `(NUM_DOMAINS-1)*STAGGER+1` and `SW_RST_CYCLES`, plus 1 bit.
- `rst_n_o` is driven from a thermometer register.

## Test plan
- Defaults, lock and ext both high from edge 0 → `rst_n_o` = 0001 @18, 0011 @26, 0111 @34, 1111 @42; `all_released_o`=1 @42.
- Lock drops for 1 cycle at edge 10 (during FILTER) → no release @18; release restarts, `rst_n_o[0]` rises 16 cycles after `good` returns; `lock_loss_cnt_o`=0.
- In RUN, lock sampled low at edge 100 → `rst_n_o`=0000 @103, `lock_loss_cnt_o`=1; lock restored → full sequence repeats. Loop 300 times → count saturates at 255.
- In RUN, `sw_rst_req_i` pulse at edge 200 → outputs 0000 @201–232; `rst_n_o[0]` @249; 1111 @273; `lock_loss_cnt_o` unchanged.
- `ext_rst_n_i` low at edge 60 while in RUN → outputs 0000 @63, counter unchanged. `sw_rst_req_i` in HOLD → ignored.
- `rst` asserted at edge 30, mid-RELEASE → all outputs 0 and counter 0 at edge 31; after `rst` deasserts, sequence restarts from synchroniser fill.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// Contents: FSM state enum, lock-loss counter width, a small max helper.
// No ports; imported by reset_sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    FILTER,
    RELEASE,
    RUN,
    SWRST
  } state_e;

  localparam int LOSS_CNT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level signal.
// Ports: clk, rst (sync active-high, loads RST_VAL), d (async in), q (synchronised out).
// Latency: a change on d appears on q after the second sampling edge.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Reset controller: qualifies PLL lock and board reset, then releases NUM_DOMAINS
// reset domains in staggered order; supports software reset and counts lock losses.
// Ports: clk, rst (sync active-high), pll_locked_i / ext_rst_n_i (async), sw_rst_req_i,
// rst_n_o (per-domain active-low), all_released_o, lock_loss_cnt_o (saturating).
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS   = 4,
  parameter int LOCK_FILTER   = 16,
  parameter int STAGGER       = 8,
  parameter int SW_RST_CYCLES = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_locked_i,
  input  logic                   ext_rst_n_i,
  input  logic                   sw_rst_req_i,
  output logic [NUM_DOMAINS-1:0] rst_n_o,
  output logic                   all_released_o,
  output logic [LOSS_CNT_W-1:0]  lock_loss_cnt_o
);

  localparam int CNT_MAX = max3(LOCK_FILTER, (NUM_DOMAINS - 1) * STAGGER + 1, SW_RST_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER);
  localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_RST_CYCLES);

  logic sync_locked;
  logic sync_ext_n;
  logic good;

  sync_2ff #(.RST_VAL(1'b0)) u_sync_lock (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked_i),
    .q   (sync_locked)
  );

  sync_2ff #(.RST_VAL(1'b0)) u_sync_ext (
    .clk (clk),
    .rst (rst),
    .d   (ext_rst_n_i),
    .q   (sync_ext_n)
  );

  assign good = sync_locked & sync_ext_n;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0]  thermo_q, thermo_d;
  logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
  logic [NUM_DOMAINS-1:0]  thermo_shift;
  logic                    start_release;

  // Next thermometer value: one more domain released.
  assign thermo_shift = (thermo_q << 1) | NUM_DOMAINS'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      thermo_q <= '0;
      loss_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      thermo_q <= thermo_d;
      loss_q   <= loss_d;
    end
  end

  // Next-state logic. The shared counter holds: good cycles seen (FILTER),
  // cycles since the last domain release (RELEASE), cycles in reset (SWRST).
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    thermo_d      = thermo_q;
    loss_d        = loss_q;
    start_release = 1'b0;

    if (!good) begin
      // Loss of qualification dominates everything, including a software request.
      state_d  = HOLD;
      cnt_d    = '0;
      thermo_d = '0;
      if ((state_q == RELEASE || state_q == RUN) && !sync_locked && loss_q != '1) begin
        loss_d = loss_q + 1'b1;
      end
    end else begin
      case (state_q)
        HOLD: begin
          // The first good cycle already counts towards the filter.
          if (LOCK_FILTER == 1) begin
            start_release = 1'b1;
          end else begin
            state_d = FILTER;
            cnt_d   = CNT_ONE;
          end
        end
        FILTER: begin
          if (cnt_q == FILT_LAST) begin
            start_release = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_q == STAG_LAST) begin
            thermo_d = thermo_shift;
            cnt_d    = CNT_ONE;
            if (&thermo_shift) begin
              state_d = RUN;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (sw_rst_req_i) begin
            state_d  = SWRST;
            cnt_d    = CNT_ONE;
            thermo_d = '0;
          end
        end
        SWRST: begin
          if (cnt_q == SW_LAST) begin
            state_d = FILTER;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d  = HOLD;
          cnt_d    = '0;
          thermo_d = '0;
        end
      endcase

      if (start_release) begin
        thermo_d = NUM_DOMAINS'(1);
        cnt_d    = CNT_ONE;
        state_d  = (NUM_DOMAINS == 1) ? RUN : RELEASE;
      end
    end
  end

  // Outputs
  always_comb begin
    rst_n_o         = thermo_q;
    all_released_o  = (state_q == RUN);
    lock_loss_cnt_o = loss_q;
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer at default parameters.
// Reference model tracks, per edge, the edge at which domain 0 becomes visible
// released ("anchor"); domain k is released from anchor + k*STAGGER.
module tb_reset_sequencer;

  localparam int N  = 4;
  localparam int LF = 16;
  localparam int S  = 8;
  localparam int SW = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pll_locked_i = 1'b0;
  logic         ext_rst_n_i = 1'b0;
  logic         sw_rst_req_i = 1'b0;
  logic [N-1:0] rst_n_o;
  logic         all_released_o;
  logic [7:0]   lock_loss_cnt_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // model state
  int ecount = -1;
  int anchor = 0;
  bit anch_v = 1'b0;
  int m_loss = 0;
  bit lk0 = 1'b0, lk1 = 1'b0, ex0 = 1'b0, ex1 = 1'b0;

  reset_sequencer #(
    .NUM_DOMAINS   (N),
    .LOCK_FILTER   (LF),
    .STAGGER       (S),
    .SW_RST_CYCLES (SW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pll_locked_i    (pll_locked_i),
    .ext_rst_n_i     (ext_rst_n_i),
    .sw_rst_req_i    (sw_rst_req_i),
    .rst_n_o         (rst_n_o),
    .all_released_o  (all_released_o),
    .lock_loss_cnt_o (lock_loss_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, got edge %0d, required completion", ecount);
    $fatal(1, "watchdog");
  end

  function automatic void model_edge(input logic lock, input logic ext, input logic req, input logic r);
    int n;
    bit g;
    n = ecount;
    if (r) begin
      lk0 = 0; lk1 = 0; ex0 = 0; ex1 = 0;
      anch_v = 0;
      m_loss = 0;
    end else begin
      g = lk1 && ex1;
      if (!g) begin
        if (anch_v && n >= anchor && !lk1 && m_loss < 255) m_loss++;
        anch_v = 0;
      end else if (!anch_v) begin
        anch_v = 1;
        anchor = n + LF;
      end else if (req && n >= anchor + (N - 1) * S) begin
        anchor = n + SW + 1 + LF;
      end
      lk1 = lk0; lk0 = lock;
      ex1 = ex0; ex0 = ext;
    end
  endfunction

  // Expected outputs visible after the most recent edge.
  function automatic logic [N-1:0] exp_rst_n();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = anch_v && (ecount + 1 >= anchor + k * S);
    return v;
  endfunction

  function automatic logic exp_all();
    return anch_v && (ecount + 1 >= anchor + (N - 1) * S);
  endfunction

  task automatic tick(input logic lock, input logic ext, input logic req, input logic r);
    pll_locked_i = lock;
    ext_rst_n_i  = ext;
    sw_rst_req_i = req;
    rst          = r;
    @(posedge clk);
    ecount++;
    model_edge(lock, ext, req, r);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b1);
      chk_cnt++;
      if (rst_n_o !== 4'b0000 || all_released_o !== 1'b0 || lock_loss_cnt_o !== 8'd0)
        $display("FAIL reset_state: rst_n=%b all=%b loss=%0d, required 0000 0 0", rst_n_o, all_released_o, lock_loss_cnt_o);
      else pass_cnt++;
    end
  endtask

  task automatic test_startup();
    int e0, rel;
    logic [3:0] want;
    bit have;
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    e0 = ecount + 1;
    for (int i = 0; i < 45; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      rel = ecount + 1 - e0;
      chk_cnt++;
      if (rst_n_o !== exp_rst_n() || all_released_o !== exp_all() || lock_loss_cnt_o !== 8'(m_loss))
        $display("FAIL model_startup edge %0d: rst_n=%b all=%b loss=%0d, expected %b %b %0d", ecount + 1, rst_n_o, all_released_o, lock_loss_cnt_o, exp_rst_n(), exp_all(), m_loss);
      else pass_cnt++;
      have = 1;
      want = 4'b0000;
      case (rel)
        17: want = 4'b0000;
        18: want = 4'b0001;
        26: want = 4'b0011;
        34: want = 4'b0111;
        41: want = 4'b0111;
        42: want = 4'b1111;
        default: have = 0;
      endcase
      if (have) begin
        chk_cnt++;
        if (rst_n_o !== want || all_released_o !== (rel >= 42))
          $display("FAIL startup_edge%0d: rst_n=%b all=%b, required %b %b", rel, rst_n_o, all_released_o, want, (rel >= 42));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_glitch();
    int e0, rel;
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    e0 = ecount + 1;
    for (int i = 0; i < 35; i++) begin
      tick((ecount + 1 - e0) != 10, 1'b1, 1'b0, 1'b0);
      rel = ecount + 1 - e0;
      chk_cnt++;
      if (rst_n_o !== exp_rst_n() || all_released_o !== exp_all() || lock_loss_cnt_o !== 8'(m_loss))
        $display("FAIL model_glitch edge %0d: rst_n=%b all=%b loss=%0d, expected %b %b %0d", ecount + 1, rst_n_o, all_released_o, lock_loss_cnt_o, exp_rst_n(), exp_all(), m_loss);
      else pass_cnt++;
      if (rel == 18 || rel == 28 || rel == 29) begin
        chk_cnt++;
        if (rst_n_o !== ((rel == 29) ? 4'b0001 : 4'b0000) || lock_loss_cnt_o !== 8'd0)
          $display("FAIL glitch_edge%0d: rst_n=%b loss=%0d, required %b 0", rel, rst_n_o, lock_loss_cnt_o, (rel == 29) ? 4'b0001 : 4'b0000);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_lock_loss();
    int want_loss, len, budget;
    want_loss = 0;
    for (int it = 0; it < 300; it++) begin
      budget = 0;
      while (all_released_o !== 1'b1 && budget < 80) begin
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        budget++;
        chk_cnt++;
        if (rst_n_o !== exp_rst_n() || all_released_o !== exp_all() || lock_loss_cnt_o !== 8'(m_loss))
          $display("FAIL model_lockloss edge %0d: rst_n=%b all=%b loss=%0d, expected %b %b %0d", ecount + 1, rst_n_o, all_released_o, lock_loss_cnt_o, exp_rst_n(), exp_all(), m_loss);
        else pass_cnt++;
      end
      if (budget >= 80) begin
        chk_cnt++;
        $display("FAIL lockloss_timeout iter %0d: all_released=%b, required 1 within 80 cycles", it, all_released_o);
      end
      len = $urandom_range(1, 3);
      want_loss = (want_loss < 255) ? want_loss + 1 : 255;
      for (int j = 0; j < 3; j++) begin
        tick(j >= len, 1'b1, 1'b0, 1'b0);
        if (j == 1) begin
          chk_cnt++;
          if (rst_n_o !== 4'b1111)
            $display("FAIL lockloss_hold iter %0d: rst_n=%b, required 1111", it, rst_n_o);
          else pass_cnt++;
        end
        if (j == 2) begin
          chk_cnt++;
          if (rst_n_o !== 4'b0000 || all_released_o !== 1'b0 || lock_loss_cnt_o !== 8'(want_loss))
            $display("FAIL lockloss_drop iter %0d: rst_n=%b all=%b loss=%0d, required 0000 0 %0d", it, rst_n_o, all_released_o, lock_loss_cnt_o, want_loss);
          else pass_cnt++;
        end
      end
    end
    chk_cnt++;
    if (lock_loss_cnt_o !== 8'd255)
      $display("FAIL lockloss_saturate: loss=%0d, required 255", lock_loss_cnt_o);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int e0, rel;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    e0 = ecount + 1;
    for (int i = 0; i < 55; i++) begin
      tick(1'b1, 1'b1, 1'b0, (ecount + 1 - e0) == 30);
      rel = ecount + 1 - e0;
      chk_cnt++;
      if (rst_n_o !== exp_rst_n() || all_released_o !== exp_all() || lock_loss_cnt_o !== 8'(m_loss))
        $display("FAIL model_midreset edge %0d: rst_n=%b all=%b loss=%0d, expected %b %b %0d", ecount + 1, rst_n_o, all_released_o, lock_loss_cnt_o, exp_rst_n(), exp_all(), m_loss);
      else pass_cnt++;
      if (rel == 26) begin
        chk_cnt++;
        if (rst_n_o !== 4'b0011 || lock_loss_cnt_o !== 8'd255)
          $display("FAIL midreset_before: rst_n=%b loss=%0d, required 0011 255", rst_n_o, lock_loss_cnt_o);
        else pass_cnt++;
      end
      if (rel == 31 || rel == 48 || rel == 49) begin
        chk_cnt++;
        if (rst_n_o !== ((rel == 49) ? 4'b0001 : 4'b0000) || all_released_o !== 1'b0 || lock_loss_cnt_o !== 8'd0)
          $display("FAIL midreset_edge%0d: rst_n=%b all=%b loss=%0d, required %b 0 0", rel, rst_n_o, all_released_o, lock_loss_cnt_o, (rel == 49) ? 4'b0001 : 4'b0000);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_sw_reset();
    int s, rel, budget;
    logic [3:0] want;
    bit have;
    budget = 0;
    while (all_released_o !== 1'b1 && budget < 80) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      budget++;
    end
    if (budget >= 80) begin
      chk_cnt++;
      $display("FAIL swrst_timeout: all_released=%b, required 1 within 80 cycles", all_released_o);
    end
    s = ecount + 1;
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 80; i++) begin
      rel = ecount + 1 - s;
      chk_cnt++;
      if (rst_n_o !== exp_rst_n() || all_released_o !== exp_all() || lock_loss_cnt_o !== 8'(m_loss))
        $display("FAIL model_swrst edge %0d: rst_n=%b all=%b loss=%0d, expected %b %b %0d", ecount + 1, rst_n_o, all_released_o, lock_loss_cnt_o, exp_rst_n(), exp_all(), m_loss);
      else pass_cnt++;
      have = 1;
      want = 4'b0000;
      case (rel)
        1:  want = 4'b0000;
        32: want = 4'b0000;
        48: want = 4'b0000;
        49: want = 4'b0001;
        72: want = 4'b0111;
        73: want = 4'b1111;
        default: have = 0;
      endcase
      if (have) begin
        chk_cnt++;
        if (rst_n_o !== want || all_released_o !== (rel == 73) || lock_loss_cnt_o !== 8'd0)
          $display("FAIL swrst_edge%0d: rst_n=%b all=%b loss=%0d, required %b %b 0", rel, rst_n_o, all_released_o, lock_loss_cnt_o, want, (rel == 73));
        else pass_cnt++;
      end
      tick(1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_ext_reset();
    int e, e0, rel, budget;
    budget = 0;
    while (all_released_o !== 1'b1 && budget < 80) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      budget++;
    end
    if (budget >= 80) begin
      chk_cnt++;
      $display("FAIL ext_timeout: all_released=%b, required 1 within 80 cycles", all_released_o);
    end
    e = ecount + 1;
    for (int j = 0; j < 10; j++) begin
      tick(1'b1, 1'b0, j == 5, 1'b0);
      rel = ecount + 1 - e;
      if (rel == 2 || rel == 3 || rel == 9) begin
        chk_cnt++;
        if (rst_n_o !== ((rel == 2) ? 4'b1111 : 4'b0000) || lock_loss_cnt_o !== 8'd0)
          $display("FAIL ext_edge%0d: rst_n=%b loss=%0d, required %b 0", rel, rst_n_o, lock_loss_cnt_o, (rel == 2) ? 4'b1111 : 4'b0000);
        else pass_cnt++;
      end
    end
    e0 = ecount + 1;
    for (int i = 0; i < 45; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      rel = ecount + 1 - e0;
      chk_cnt++;
      if (rst_n_o !== exp_rst_n() || all_released_o !== exp_all() || lock_loss_cnt_o !== 8'(m_loss))
        $display("FAIL model_ext edge %0d: rst_n=%b all=%b loss=%0d, expected %b %b %0d", ecount + 1, rst_n_o, all_released_o, lock_loss_cnt_o, exp_rst_n(), exp_all(), m_loss);
      else pass_cnt++;
      if (rel == 17 || rel == 18 || rel == 42) begin
        chk_cnt++;
        if (rst_n_o !== ((rel == 17) ? 4'b0000 : (rel == 18) ? 4'b0001 : 4'b1111))
          $display("FAIL ext_restart_edge%0d: rst_n=%b, required %b", rel, rst_n_o, (rel == 17) ? 4'b0000 : (rel == 18) ? 4'b0001 : 4'b1111);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_random();
    logic lock, ext, req, r;
    for (int i = 0; i < 3000; i++) begin
      lock = ($urandom_range(0, 59) != 0);
      ext  = ($urandom_range(0, 119) != 0);
      req  = ($urandom_range(0, 15) == 0);
      r    = ($urandom_range(0, 799) == 0);
      tick(lock, ext, req, r);
      chk_cnt++;
      if (rst_n_o !== exp_rst_n() || all_released_o !== exp_all() || lock_loss_cnt_o !== 8'(m_loss))
        $display("FAIL model_random edge %0d: rst_n=%b all=%b loss=%0d, expected %b %b %0d", ecount + 1, rst_n_o, all_released_o, lock_loss_cnt_o, exp_rst_n(), exp_all(), m_loss);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_glitch();
    test_lock_loss();
    test_mid_reset();
    test_sw_reset();
    test_ext_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
